// File: rtl/switch_debounce_2ch_if.sv
// Signal bundle between raw board switches and the two-channel debouncer.
// Edge-pulse signals exist only when DEBOUNCE_EDGE_EN is defined.
interface switch_debounce_2ch_if;
  logic sw_a;
  logic sw_b;
  logic a;
  logic b;
`ifdef DEBOUNCE_EDGE_EN
  logic a_edge;
  logic b_edge;

  modport master (output sw_a, output sw_b, input a, input b, input a_edge, input b_edge);
  modport slave  (input sw_a, input sw_b, output a, output b, output a_edge, output b_edge);
`else
  modport master (output sw_a, output sw_b, input a, input b);
  modport slave  (input sw_a, input sw_b, output a, output b);
`endif
endinterface

// File: rtl/switch_debounce_2ch.sv
// Two independent switch conditioners: 2-FF synchroniser plus counting debouncer per channel.
// Optional macro DEBOUNCE_EDGE_EN adds registered one-cycle change pulses a_edge/b_edge.
module switch_debounce_2ch #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  switch_debounce_2ch_if.slave  dbus
);

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_COUNTING = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LP_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam bit               LP_ONE_SHOT = (DEBOUNCE_CYCLES == 1);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > (2**CNT_W) - 1) begin : g_cfg_err
    $error("switch_debounce_2ch: DEBOUNCE_CYCLES=%0d illegal for CNT_W=%0d",
           DEBOUNCE_CYCLES, CNT_W);
  end

  logic [1:0] w_sw;
  logic [1:0] w_out;
  assign w_sw   = {dbus.sw_b, dbus.sw_a};
  assign dbus.a = w_out[0];
  assign dbus.b = w_out[1];

`ifdef DEBOUNCE_EDGE_EN
  logic [1:0] w_edge;
  assign dbus.a_edge = w_edge[0];
  assign dbus.b_edge = w_edge[1];
`endif

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    logic             r_s1, r_s2;
    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_out, w_out_nxt;
    logic             w_diff;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_s1 <= 1'b0;
        r_s2 <= 1'b0;
      end else begin
        r_s1 <= w_sw[ch];
        r_s2 <= r_s1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state <= ST_STABLE;
        r_cnt   <= '0;
        r_out   <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
        r_out   <= w_out_nxt;
      end
    end

    assign w_diff = (r_s2 != r_out);

    always_comb begin
      // NOTE: defaults first so every path assigns every output; no latch can be inferred.
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_out_nxt   = r_out;
      unique case (r_state)
        ST_STABLE: begin
          w_cnt_nxt = '0;
          if (w_diff) begin
            if (LP_ONE_SHOT) begin
              w_out_nxt = r_s2;
            end else begin
              w_state_nxt = ST_COUNTING;
              w_cnt_nxt   = CNT_W'(1);
            end
          end
        end
        ST_COUNTING: begin
          if (!w_diff) begin
            w_state_nxt = ST_STABLE;
            w_cnt_nxt   = '0;
          end else if (r_cnt == LP_LAST) begin
            // Enough consecutive disagreeing samples: accept the new level.
            w_out_nxt   = r_s2;
            w_state_nxt = ST_STABLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt = ST_STABLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end

    assign w_out[ch] = r_out;

`ifdef DEBOUNCE_EDGE_EN
    logic r_edge;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_edge <= 1'b0;
      else        r_edge <= (w_out_nxt != r_out);
    end
    assign w_edge[ch] = r_edge;
`endif
  end

endmodule

// File: tb/tb_switch_debounce_2ch.sv
// Self-checking bench for switch_debounce_2ch (DEBOUNCE_CYCLES=4, CNT_W=4): directed scenarios
// plus randomized switch activity checked against a sliding-window reference model.
module tb_switch_debounce_2ch;

  localparam int DC  = 4;
  localparam int LAT = DC + 2;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  switch_debounce_2ch_if ifc ();

  switch_debounce_2ch #(
    .DEBOUNCE_CYCLES (DC),
    .CNT_W           (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .dbus  (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: a channel's level flips once its last DC synchronised samples all disagree with it.
  bit [1:0]    m_dly  [2];
  bit [DC-1:0] m_win  [2];
  bit          m_out  [2];
  bit          m_edge [2];

  function automatic bit settles(bit [DC-1:0] win, bit smp, bit cur);
    bit [DC-1:0] nw;
    nw = {win[DC-2:0], smp};
    return nw == {DC{~cur}};
  endfunction

  function automatic bit sw_of(int ch);
    return (ch == 0) ? ifc.sw_a : ifc.sw_b;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int ch = 0; ch < 2; ch++) begin
        m_dly[ch]  <= '0;
        m_win[ch]  <= '0;
        m_out[ch]  <= 1'b0;
        m_edge[ch] <= 1'b0;
      end
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        m_dly[ch] <= {m_dly[ch][0], sw_of(ch)};
        m_win[ch] <= {m_win[ch][DC-2:0], m_dly[ch][1]};
        if (settles(m_win[ch], m_dly[ch][1], m_out[ch])) begin
          m_out[ch]  <= ~m_out[ch];
          m_edge[ch] <= 1'b1;
        end else begin
          m_edge[ch] <= 1'b0;
        end
      end
    end
  end

  task automatic do_reset(input logic va, input logic vb);
    @(negedge clk);
    rst_n    = 1'b0;
    ifc.sw_a = va;
    ifc.sw_b = vb;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    ifc.sw_a = 1'b1;
    ifc.sw_b = 1'b1;
    rst_n    = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (ifc.a !== 1'b0 || ifc.b !== 1'b0) begin
      n_err++;
      $display("FAIL reset_async: a=%b b=%b required 0 0", ifc.a, ifc.b);
    end
`ifdef DEBOUNCE_EDGE_EN
    n_cmp++;
    if (ifc.a_edge !== 1'b0 || ifc.b_edge !== 1'b0) begin
      n_err++;
      $display("FAIL reset_edge: a_edge=%b b_edge=%b required 0 0", ifc.a_edge, ifc.b_edge);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      n_cmp++;
      if (ifc.a !== 1'b0 || ifc.b !== 1'b0) begin
        n_err++;
        $display("FAIL reset_hold cyc%0d: a=%b b=%b required 0 0", i, ifc.a, ifc.b);
      end
    end
  endtask

  task automatic test_clean_rise();
    do_reset(1'b0, 1'b0);
    repeat (3) @(negedge clk);
    ifc.sw_a = 1'b1;
    repeat (LAT - 1) @(negedge clk);
    n_cmp++;
    if (ifc.a !== 1'b0) begin
      n_err++;
      $display("FAIL rise_early: a=%b required 0 after edge %0d", ifc.a, LAT - 1);
    end
    @(negedge clk);
    n_cmp++;
    if (ifc.a !== 1'b1 || ifc.b !== 1'b0) begin
      n_err++;
      $display("FAIL rise_on_time: a=%b b=%b required 1 0 after edge %0d", ifc.a, ifc.b, LAT);
    end
  endtask

  task automatic test_bounce();
    logic [6:0] pat;
    pat = 7'b1111011;  // bit i is the level driven in cycle i
    do_reset(1'b0, 1'b0);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      ifc.sw_a = pat[i];
      @(negedge clk);
    end
    for (int i = 3; i < 7; i++) begin
      ifc.sw_a = pat[i];
      @(negedge clk);
    end
    // Final run of 1s began at cycle 3; four of its edges are already past.
    n_cmp++;
    if (ifc.a !== 1'b0) begin
      n_err++;
      $display("FAIL bounce_reject: a=%b required 0 after 4 edges of final run", ifc.a);
    end
    @(negedge clk);
    n_cmp++;
    if (ifc.a !== 1'b0) begin
      n_err++;
      $display("FAIL bounce_early: a=%b required 0 after 5 edges of final run", ifc.a);
    end
    @(negedge clk);
    n_cmp++;
    if (ifc.a !== 1'b1) begin
      n_err++;
      $display("FAIL bounce_settle: a=%b required 1 after 6 edges of final run", ifc.a);
    end
  endtask

  task automatic test_fall_simultaneous();
    do_reset(1'b1, 1'b1);
    repeat (LAT + 2) @(negedge clk);
    n_cmp++;
    if (ifc.a !== 1'b1 || ifc.b !== 1'b1) begin
      n_err++;
      $display("FAIL fall_setup: a=%b b=%b required 1 1", ifc.a, ifc.b);
    end
    ifc.sw_a = 1'b0;
    ifc.sw_b = 1'b0;
    repeat (LAT - 1) @(negedge clk);
    n_cmp++;
    if (ifc.a !== 1'b1 || ifc.b !== 1'b1) begin
      n_err++;
      $display("FAIL fall_early: a=%b b=%b required 1 1", ifc.a, ifc.b);
    end
    @(negedge clk);
    n_cmp++;
    if (ifc.a !== 1'b0 || ifc.b !== 1'b0) begin
      n_err++;
      $display("FAIL fall_together: a=%b b=%b required 0 0", ifc.a, ifc.b);
    end
  endtask

  task automatic test_midcount_reset();
    do_reset(1'b0, 1'b0);
    repeat (3) @(negedge clk);
    ifc.sw_a = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (ifc.a !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_out: a=%b required 0", ifc.a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (LAT - 1) @(negedge clk);
    n_cmp++;
    if (ifc.a !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_early: a=%b required 0 after edge %0d", ifc.a, LAT - 1);
    end
    @(negedge clk);
    n_cmp++;
    if (ifc.a !== 1'b1) begin
      n_err++;
      $display("FAIL midreset_latency: a=%b required 1 after edge %0d", ifc.a, LAT);
    end
  endtask

`ifdef DEBOUNCE_EDGE_EN
  task automatic test_edge_pulse();
    int pulses;
    int at;
    do_reset(1'b0, 1'b0);
    repeat (3) @(negedge clk);
    for (int dir = 1; dir >= 0; dir--) begin
      ifc.sw_a = dir[0];
      pulses   = 0;
      at       = -1;
      for (int c = 1; c <= LAT + 4; c++) begin
        @(negedge clk);
        if (ifc.a_edge === 1'b1) begin
          pulses++;
          if (at < 0) at = c;
        end
      end
      n_cmp++;
      if (pulses !== 1 || at !== LAT) begin
        n_err++;
        $display("FAIL edge_pulse dir=%0d: pulses=%0d at cycle %0d required 1 at %0d",
                 dir, pulses, at, LAT);
      end
    end
    ifc.sw_a = 1'b1;
    repeat (2) @(negedge clk);
    ifc.sw_a = 1'b0;
    pulses = 0;
    for (int c = 0; c < LAT + 4; c++) begin
      @(negedge clk);
      if (ifc.a_edge === 1'b1) pulses++;
    end
    n_cmp++;
    if (pulses !== 0 || ifc.a !== 1'b0) begin
      n_err++;
      $display("FAIL edge_bounce: pulses=%0d a=%b required 0 0", pulses, ifc.a);
    end
  endtask
`endif

  task automatic test_random();
    int hold [2];
    int bad;
    do_reset(1'b0, 1'b0);
    hold[0] = 0;
    hold[1] = 0;
    bad     = 0;
    for (int cyc = 0; cyc < 1200; cyc++) begin
      @(negedge clk);
      if (ifc.a !== m_out[0] || ifc.b !== m_out[1]) begin
        if (bad < 10)
          $display("FAIL random_level cyc%0d: a=%b b=%b required %b %b",
                   cyc, ifc.a, ifc.b, m_out[0], m_out[1]);
        bad++;
      end
`ifdef DEBOUNCE_EDGE_EN
      if (ifc.a_edge !== m_edge[0] || ifc.b_edge !== m_edge[1]) begin
        if (bad < 10)
          $display("FAIL random_edge cyc%0d: a_edge=%b b_edge=%b required %b %b",
                   cyc, ifc.a_edge, ifc.b_edge, m_edge[0], m_edge[1]);
        bad++;
      end
`endif
      for (int ch = 0; ch < 2; ch++) begin
        if (hold[ch] == 0) begin
          // Mostly short holds (bounce-like) with occasional long ones that must settle.
          hold[ch] = ($urandom_range(0, 3) == 0) ? $urandom_range(DC + 2, 12)
                                                 : $urandom_range(1, DC + 1);
          if (ch == 0) ifc.sw_a = $urandom_range(0, 1);
          else         ifc.sw_b = $urandom_range(0, 1);
        end
        hold[ch]--;
      end
    end
    n_cmp++;
    if (bad !== 0) begin
      n_err++;
      $display("FAIL random_summary: %0d disagreeing cycles, required 0", bad);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    rst_n    = 1'b1;
    ifc.sw_a = 1'b0;
    ifc.sw_b = 1'b0;
    test_reset();
    test_clean_rise();
    test_bounce();
    test_fall_simultaneous();
    test_midcount_reset();
`ifdef DEBOUNCE_EDGE_EN
    test_edge_pulse();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
